// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   state_e          : arbiter FSM state encoding (IDLE / GRANT)
//   MAX_HOLD_DEFAULT : default limit on consecutive contended grant cycles
//   PTR_RESET        : round-robin pointer value after reset (requester 0 first)
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned MAX_HOLD_DEFAULT = 32'd8;
    localparam logic [1:0]  PTR_RESET        = 2'b11;

endpackage

// File: rtl/decoder_2x4.sv
// 2-to-4 one-hot decoder with enable.
//   idx_i : binary index
//   en_i  : when low the output is all-zero
//   dec_o : one-hot decode of idx_i (or zero)
module decoder_2x4 (
    input  logic [1:0] idx_i,
    input  logic       en_i,
    output logic [3:0] dec_o
);

    // Combinational one-hot decode, gated by enable.
    always_comb begin
        dec_o = 4'b0000;
        if (en_i) begin
            case (idx_i)
                2'd0:    dec_o = 4'b0001;
                2'd1:    dec_o = 4'b0010;
                2'd2:    dec_o = 4'b0100;
                2'd3:    dec_o = 4'b1000;
                default: dec_o = 4'b0000;
            endcase
        end else begin
            dec_o = 4'b0000;
        end
    end

endmodule

// File: rtl/rr_arb_4.sv
// 4-requester round-robin arbiter with bounded hold under contention.
//   clk       : clock, rising-edge
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i = requester i
//   gnt       : one-hot grant, zero when idle
//   gnt_idx   : index of current grantee, holds last value when idle
//   gnt_valid : high while a grant is active
// A grant ends when its owner drops req (release) or when it has been held
// MAX_HOLD cycles while someone else is waiting (revoke). The next winner is
// granted on the same edge, so a busy arbiter never inserts an idle cycle.
module rr_arb_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    // Low for the first edge after reset so no grant is issued on that edge.
    logic       arm_q;

    logic       win_found_s;
    logic [1:0] win_idx_s;
    logic [1:0] cand_s;
    logic       release_s;
    logic       revoke_s;
    logic [3:0] others_s;

    // Round-robin scan starting just after the last grantee. The owner's bit
    // is zero on release and sits last in the scan on revoke, so raw req
    // serves as the candidate mask in every case.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = ptr_q;
        cand_s      = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // End-of-grant conditions for the current owner.
    always_comb begin
        others_s  = req & ~(4'b0001 << idx_q);
        release_s = ~req[idx_q];
        revoke_s  = (cnt_q == HOLD_LAST) && (others_s != 4'b0000);
    end

    // Next-state logic: new grant, hold, or return to idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arm_q && win_found_s) begin
                    state_d = GRANT;
                    ptr_d   = win_idx_s;
                    idx_d   = win_idx_s;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s || revoke_s) begin
                    if (win_found_s) begin
                        state_d = GRANT;
                        ptr_d   = win_idx_s;
                        idx_d   = win_idx_s;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RESET;
            idx_q   <= 2'b00;
            cnt_q   <= 8'd0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            arm_q   <= 1'b1;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    decoder_2x4 u_dec (
        .idx_i (idx_q),
        .en_i  (gnt_valid),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_rr_arb_4.sv
module tb_rr_arb_4;

    localparam int MAX_HOLD = 8;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    exp_t exp_q[$];

    // Reference model state: who owns the resource, how many cycles it has
    // been visible, the last winner, and edges seen since reset release.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_last;
    int m_edges;

    rr_arb_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_held  = 0;
        m_last  = 0;
        m_edges = 0;
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_ptr   = w;
        m_last  = w;
        m_held  = 1;
    endtask

    // One rising edge of the reference arbiter with request vector r.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] others;
        int w;
        if (m_edges == 0) begin
            m_edges = 1;
        end else if (m_owner < 0) begin
            w = rr_pick(m_ptr, r);
            if (w >= 0) take(w);
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                w = rr_pick(m_ptr, others);
                if (w >= 0) take(w); else m_owner = -1;
            end else if (m_held >= MAX_HOLD && others != 4'b0000) begin
                w = rr_pick(m_ptr, r);
                take(w);
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic drive_now(input logic [3:0] r);
        exp_t e;
        req = r;
        model_edge(r);
        e.v   = (m_owner >= 0);
        e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.idx = 2'(m_last);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] r);
        @(negedge clk);
        drive_now(r);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard comparison.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (!($countones(gnt) <= 1 && gnt_valid === (gnt != 4'b0000))) begin
                    errors++;
                    $display("FAIL invariant: gnt=%b gnt_valid=%b at %0t", gnt, gnt_valid, $time);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("gnt", {4'b0000, gnt}, {4'b0000, e.gnt});
                    chk("gnt_valid", {7'b0, gnt_valid}, {7'b0, e.v});
                    chk("gnt_idx", {6'b0, gnt_idx}, {6'b0, e.idx});
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        model_reset();
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_gnt", {4'b0, gnt}, 8'h00);
        chk("reset_valid", {7'b0, gnt_valid}, 8'h00);
        chk("reset_idx", {6'b0, gnt_idx}, 8'h00);

        // Single requester 0; first edge after release must not grant.
        @(negedge clk);
        rst_n = 1'b1;
        drive_now(4'b0001);
        repeat (4) cycle(4'b0001);
        repeat (2) cycle(4'b0000);

        // Full contention: rotation with MAX_HOLD-cycle slices.
        repeat (40) cycle(4'b1111);
        repeat (2) cycle(4'b0000);

        // Owner 2 drops while 3 and 0 appear: 3 must win.
        repeat (3) cycle(4'b0100);
        repeat (3) cycle(4'b1001);
        repeat (2) cycle(4'b0000);

        // Lone requester never revoked.
        repeat (20) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        // Randomized traffic with sticky requests.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r);
        end

        // Asynchronous reset in the middle of a grant.
        repeat (3) cycle(4'b0110);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", {4'b0, gnt}, 8'h00);
        chk("async_rst_valid", {7'b0, gnt_valid}, 8'h00);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_now(4'b0110);
        repeat (4) cycle(4'b0110);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before a contended grant is revoked; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 gnt  output  4  one-hot grant vector; all-zero when no grant is active.
REQ-006 gnt_idx  output  2  binary index of the current grantee; holds its last value when gnt_valid=0.
REQ-007 gnt_valid  output  1  high while exactly one gnt bit is set.

Function
REQ-008 The block SHALL implement a two-state machine: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-009 IDLE: if req != 0 at a rising edge, the block SHALL select a winner and enter GRANT; gnt is visible the following cycle (1-cycle request-to-grant latency).
REQ-010 Winner selection SHALL be round-robin: scan indices ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins; ptr is the index of the most recently granted requester.
REQ-011 On each new grant, ptr SHALL be loaded with the winner index and hold_cnt SHALL be cleared to 0.
REQ-012 gnt SHALL equal the 2-to-4 one-hot decode of gnt_idx when gnt_valid=1, and 4'b0000 otherwise; gnt SHALL never have more than one bit set.
REQ-013 GRANT: while req[gnt_idx]=1 and no revoke condition applies, gnt SHALL hold and hold_cnt SHALL increment by 1 per cycle, saturating at MAX_HOLD-1.
REQ-014 Release: if req[gnt_idx]=0 at an edge, the grant SHALL end at that edge.
REQ-015 Revoke: if hold_cnt = MAX_HOLD-1 and at least one other req bit is set at an edge, the grant SHALL end at that edge.
REQ-016 On release or revoke, if any req bit remains set (after excluding the released bit on release), the next winner SHALL be granted at that same edge (no idle cycle, back-to-back); otherwise the block SHALL enter IDLE with gnt_valid=0.
REQ-017 If hold_cnt = MAX_HOLD-1 and no other requester is pending, the grant SHALL continue with hold_cnt saturated (no revoke without contention).
REQ-018 A revoked requester still asserting req SHALL be re-granted only after every other pending requester, per REQ-010 ordering.
REQ-019 Requests arriving or dropping for non-granted indices during GRANT SHALL NOT affect the current grant.
REQ-020 hold_cnt width SHALL be 8 bits; no wrap-around shall occur.

Reset
REQ-021 While rst_n=0: state=IDLE, gnt=4'b0000, gnt_valid=0, gnt_idx=2'b00, hold_cnt=0, ptr=2'b11 (requester 0 has first priority after reset).
REQ-022 Reset assertion mid-grant SHALL clear gnt asynchronously, without waiting for a clock edge.
REQ-023 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge following deassertion.

Structure
REQ-024 State encodings (IDLE=1'b0, GRANT=1'b1) and the MAX_HOLD default SHALL live in the shared package arb_pkg.
REQ-025 The one-hot grant decode SHALL be a separate sub-module, decoder_2x4 (inputs: 2-bit index, enable; output: 4-bit one-hot), instantiated once.
REQ-026 Round-robin winner selection SHALL be combinational logic within rr_arb_4; all outputs SHALL be registered or decoded directly from registers.

Verification
REQ-027 Reset, then req=4'b0001 held -> gnt=4'b0001, gnt_idx=0, gnt_valid=1 one cycle after req is sampled.
REQ-028 req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0, each lasting exactly 8 cycles, with no gap between grants.
REQ-029 Grant to requester 2 active, req changes 4'b0100->4'b1001 -> next edge gnt=4'b1000 (idx 3 precedes 0 after ptr=2).
REQ-030 req=4'b0010 alone held for 20 cycles -> gnt=4'b0010 continuously; hold_cnt saturates at 7 and there is no revoke.
REQ-031 rst_n pulsed low mid-grant with req=4'b0110 -> gnt=4'b0000 immediately; after release, first grant goes to requester 1.
REQ-032 Every cycle, a bench assertion checks that gnt is zero or one-hot and that gnt_valid equals (gnt != 0).
